// File: rtl/config_updater_if.sv
// Request/grant handshake between the config updater and the SRAM arbiter.
interface config_updater_if;
  logic bus_req;
  logic bus_gnt;

  modport master (output bus_req, input bus_gnt);
  modport slave  (input bus_req, output bus_gnt);
endinterface

// File: rtl/config_updater.sv
// Holds the live VGA/scanline flags, applies hotkey toggles and writes the
// flags back to the SRAM config byte with a read-modify-write.
module config_updater #(
  parameter logic [20:0] CFG_ADDR = 21'h008FD5,
  parameter int          RD_WAIT  = 2,
  parameter int          WE_SETUP = 1,
  parameter int          WE_PULSE = 2,
  parameter int          WE_HOLD  = 1
) (
  input  logic              clk,
  input  logic              pwon_reset_n,
  input  logic              vga_on_init,
  input  logic              scanlines_on_init,
  input  logic              toggle_vga,
  input  logic              toggle_scanlines,
  config_updater_if.master  bus,
  output logic              vga_on,
  output logic              scanlines_on,
  output logic              busy,
  output logic              save_done,
  output wire  [20:0]       sram_addr,
  inout  wire  [7:0]        sram_data,
  output wire               sram_we_n
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    LOAD, IDLE, REQ, RD, WR_SETUP, WR_PULSE, WR_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_lim;
  logic            phase_last;
  logic            dirty;
  logic [7:0]      wr_byte;
  logic            granted, wr_phase, tog_any;
  logic            vga_nxt, scan_nxt;

  assign tog_any  = toggle_vga | toggle_scanlines;
  assign vga_nxt  = vga_on ^ toggle_vga;
  assign scan_nxt = scanlines_on ^ toggle_scanlines;

  // Last cycle of each timed phase.
  always_comb begin
    cnt_lim = '0;
    case (state_q)
      RD:       cnt_lim = CW'(RD_WAIT - 1);
      WR_SETUP: cnt_lim = CW'(WE_SETUP - 1);
      WR_PULSE: cnt_lim = CW'(WE_PULSE - 1);
      WR_HOLD:  cnt_lim = CW'(WE_HOLD - 1);
      default:  cnt_lim = '0;
    endcase
  end

  assign phase_last = (cnt_q == cnt_lim);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      LOAD:     state_d = IDLE;
      IDLE:     if (dirty) state_d = REQ;
      REQ:      if (bus.bus_gnt) state_d = RD;
      RD:       if (phase_last) state_d = WR_SETUP; else cnt_d = cnt_q + 1'b1;
      WR_SETUP: if (phase_last) state_d = WR_PULSE; else cnt_d = cnt_q + 1'b1;
      WR_PULSE: if (phase_last) state_d = WR_HOLD;  else cnt_d = cnt_q + 1'b1;
      WR_HOLD:  if (phase_last) state_d = IDLE;     else cnt_d = cnt_q + 1'b1;
      default:  state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge pwon_reset_n) begin
    if (!pwon_reset_n) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      vga_on       <= 1'b0;
      scanlines_on <= 1'b0;
      dirty        <= 1'b0;
      wr_byte      <= '0;
      save_done    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      save_done <= (state_q == WR_HOLD) && phase_last;
      if (state_q == LOAD) begin
        vga_on       <= vga_on_init;
        scanlines_on <= scanlines_on_init;
      end else begin
        vga_on       <= vga_nxt;
        scanlines_on <= scan_nxt;
      end
      // Merge uses flags including a toggle on this edge; such a toggle
      // keeps dirty set so another save follows.
      if (state_q == RD && phase_last) begin
        wr_byte <= (sram_data & 8'hFC) | {6'b0, scan_nxt, vga_nxt};
        dirty   <= tog_any;
      end else if (state_q != LOAD && tog_any) begin
        dirty <= 1'b1;
      end
    end
  end

  assign granted  = (state_q == RD) || (state_q == WR_SETUP) ||
                    (state_q == WR_PULSE) || (state_q == WR_HOLD);
  assign wr_phase = (state_q == WR_SETUP) || (state_q == WR_PULSE) ||
                    (state_q == WR_HOLD);

  assign busy        = granted || (state_q == REQ);
  assign bus.bus_req = busy;

  // Bus pins are decoded from registered state only, so they move together.
  assign sram_addr = granted  ? CFG_ADDR : {21{1'bz}};
  assign sram_we_n = granted  ? (state_q != WR_PULSE) : 1'bz;
  assign sram_data = wr_phase ? wr_byte : {8{1'bz}};

endmodule

// File: tb/tb_config_updater.sv
// Scoreboard bench: arbiter + SRAM model, expected write-back bytes queued
// by the stimulus and checked on each save_done.
module tb_config_updater;
  localparam logic [20:0] CFG = 21'h008FD5;
  localparam int RD_WAIT = 2;
  localparam int WE_PULSE = 2;
  localparam int BUSY_CYC = 9;

  logic clk = 1'b0;
  logic pwon_reset_n = 1'b0;
  logic vga_on_init = 1'b1;
  logic scanlines_on_init = 1'b0;
  logic toggle_vga = 1'b0;
  logic toggle_scanlines = 1'b0;
  logic vga_on, scanlines_on, busy, save_done;
  wire [20:0] sram_addr;
  wire [7:0]  sram_data;
  wire        sram_we_n;

  config_updater_if bus_if();

  config_updater #(.CFG_ADDR(CFG)) dut (
    .clk(clk), .pwon_reset_n(pwon_reset_n),
    .vga_on_init(vga_on_init), .scanlines_on_init(scanlines_on_init),
    .toggle_vga(toggle_vga), .toggle_scanlines(toggle_scanlines),
    .bus(bus_if.master),
    .vga_on(vga_on), .scanlines_on(scanlines_on),
    .busy(busy), .save_done(save_done),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Environment: arbiter grants 3 cycles after request; SRAM model
  logic [7:0]  mem = 8'hA4;
  int          kq = 0;
  int          req_cnt = 0;
  int          we_low = 0;
  logic        pend = 1'b0;
  logic [7:0]  wr_lat = '0;
  logic [20:0] wr_addr = '0;

  always @(posedge clk) kq <= (bus_if.bus_req && bus_if.bus_gnt) ? kq + 1 : 0;

  assign sram_data = (kq >= 1 && kq <= RD_WAIT) ? mem : 8'bz;

  always @(negedge clk) begin
    if (bus_if.bus_req) begin
      req_cnt++;
      if (req_cnt >= 3) bus_if.bus_gnt = 1'b1;
    end else begin
      req_cnt = 0;
      bus_if.bus_gnt = 1'b0;
    end
    if (kq == 1) we_low = 0;
    if (bus_if.bus_req && kq >= 1 && kq <= 6) begin
      if (sram_we_n == 1'b0) begin
        we_low++;
        wr_lat = sram_data;
        wr_addr = sram_addr;
        pend = 1'b1;
      end else if (pend) begin
        if (wr_addr == CFG) mem = wr_lat;
        pend = 1'b0;
      end
    end else begin
      pend = 1'b0;
    end
  end

  // Monitor: every save_done pops one expected byte
  int bcnt = 0;
  always @(negedge clk) begin
    if (busy) bcnt++;
    else if (save_done && pwon_reset_n) begin
      if (sb.size() == 0) begin
        chk("unexpected_save", 32'(mem), 32'hFFFF);
      end else begin
        chk("sram_byte", 32'(mem), 32'(sb.pop_front()));
        chk("we_low_cycles", 32'(we_low), 32'(WE_PULSE));
        chk("busy_cycles", 32'(bcnt), 32'(BUSY_CYC));
      end
      bcnt = 0;
    end else bcnt = 0;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse(input logic tv, input logic ts);
    toggle_vga = tv;
    toggle_scanlines = ts;
    @(negedge clk);
    toggle_vga = 1'b0;
    toggle_scanlines = 1'b0;
  endtask

  task automatic wait_gnt(input string nm);
    logic ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      if (bus_if.bus_gnt) ok = 1'b1;
    end
    chk(nm, 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm);
    logic ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !bus_if.bus_req) ok = 1'b1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic do_reset(input logic vi, input logic si);
    vga_on_init = vi;
    scanlines_on_init = si;
    pwon_reset_n = 1'b0;
    tick(2);
    pwon_reset_n = 1'b1;
    tick(1);
  endtask

  logic req_seen;
  logic az, dz, wz;

  initial begin
    // Reset values
    tick(2);
    chk("rst_vga", 32'(vga_on), 32'd0);
    chk("rst_busreq", 32'(bus_if.bus_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(save_done), 32'd0);
    az = (sram_addr === 21'bz);
    wz = (sram_we_n === 1'bz);
    chk("rst_addr_z", 32'(az), 32'd1);
    chk("rst_we_z", 32'(wz), 32'd1);

    // LOAD picks up init flags, no write-back
    pwon_reset_n = 1'b1;
    tick(1);
    chk("load_vga", 32'(vga_on), 32'd1);
    chk("load_scan", 32'(scanlines_on), 32'd0);
    req_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_if.bus_req) req_seen = 1'b1;
    end
    chk("no_req_after_load", 32'(req_seen), 32'd0);

    // Toggle scanlines from 0/0: A4 -> A6
    do_reset(1'b0, 1'b0);
    chk("reload_vga", 32'(vga_on), 32'd0);
    sb.push_back(8'hA6);
    pulse(1'b0, 1'b1);
    chk("scan_toggled", 32'(scanlines_on), 32'd1);
    wait_done("save1_done");

    // Toggle vga in first RD cycle: merged into the single save
    sb.push_back(8'hA5);
    pulse(1'b0, 1'b1);
    wait_gnt("rd_gnt");
    pulse(1'b1, 1'b0);
    chk("vga_toggled_rd", 32'(vga_on), 32'd1);
    wait_done("save2_done");
    tick(20);
    chk("no_extra_save", 32'(sb.size()), 32'd0);

    // Toggle vga during WR_PULSE: two saves, final byte matches flags
    sb.push_back(8'hA7);
    sb.push_back(8'hA6);
    pulse(1'b0, 1'b1);
    wait_gnt("wp_gnt");
    tick(3);
    pulse(1'b1, 1'b0);
    chk("vga_toggled_wp", 32'(vga_on), 32'd0);
    wait_done("save3_done");
    chk("final_byte", 32'(mem), 32'hA6);

    // Both toggles same cycle from 0/0
    do_reset(1'b0, 1'b0);
    sb.push_back(8'hA7);
    pulse(1'b1, 1'b1);
    chk("both_vga", 32'(vga_on), 32'd1);
    chk("both_scan", 32'(scanlines_on), 32'd1);
    wait_done("save4_done");

    // Reset asserted in WR_SETUP: bus released at once, byte kept
    pulse(1'b1, 1'b0);
    wait_gnt("ws_gnt");
    tick(2);
    vga_on_init = 1'b1;
    scanlines_on_init = 1'b0;
    #1;
    pwon_reset_n = 1'b0;
    #1;
    az = (sram_addr === 21'bz);
    dz = (sram_data === 8'bz);
    wz = (sram_we_n === 1'bz);
    chk("arst_addr_z", 32'(az), 32'd1);
    chk("arst_data_z", 32'(dz), 32'd1);
    chk("arst_we_z", 32'(wz), 32'd1);
    chk("arst_busreq", 32'(bus_if.bus_req), 32'd0);
    tick(3);
    chk("arst_mem", 32'(mem), 32'hA7);
    pwon_reset_n = 1'b1;
    tick(1);
    chk("arst_reload_vga", 32'(vga_on), 32'd1);
    chk("arst_reload_scan", 32'(scanlines_on), 32'd0);
    tick(20);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("mem_final", 32'(mem), 32'hA7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
